// File: rtl/async_fifo_pkg.sv
// Shared helpers for the parametrised dual-clock FIFO: Gray/binary
// conversion on a fixed-width container and the pointer/level width helper.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  // Pointers and levels carry one extra bit beyond the address to tell full from empty.
  function automatic int level_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_param_sync.sv
// Multi-flop bus synchronizer used for the Gray pointer crossings.
// Only Gray-coded values (one bit changing at a time) may pass through it.
module ndff_bus_sync
  import async_fifo_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the incoming bus through STAGES flops clocked in the destination domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO with register-array storage, Gray pointer
// crossings, registered full/empty/almost flags and occupancy levels.
// Optional sticky overflow/underflow flags: define ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo_param
  import async_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = (1 << ADDR_W) - 4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [WIDTH-1:0]  wdata,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  input  logic              rinc,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic              woverflow,
  output logic              runderflow
`endif
);

  localparam int PW    = level_width(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;
  // Full when the write Gray pointer differs from the read one only in its top two bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wbin, wptr, wq_rptr, wq_rbin, wbin_next, wgray_next, wlevel_next;
  logic [PW-1:0] rbin, rptr, rq_wptr, rq_wbin, rbin_next, rgray_next, rlevel_next;
  logic          wen, ren;

  ndff_bus_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (rst_n),
    .d     (rptr),
    .q     (wq_rptr)
  );

  ndff_bus_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk   (rclk),
    .rst_n (rst_n),
    .d     (wptr),
    .q     (rq_wptr)
  );

  // Write side next-state: accept, advance the pointer and measure occupancy.
  always_comb begin
    wen         = winc & ~wfull;
    wbin_next   = wbin + PW'(wen);
    wgray_next  = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
    wq_rbin     = PW'(gray2bin(PTR_MAX_W'(wq_rptr)));
    wlevel_next = wbin_next - wq_rbin;
  end

  // Write pointers and write-side flags, all registered from next-state values.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == (wq_rptr ^ FULL_MASK));
      walmost_full <= (wlevel_next >= AFULL_LV);
      wlevel       <= wlevel_next;
    end
  end

  // Storage is written only on an accepted write; contents need no reset.
  always_ff @(posedge wclk) begin
    if (wen) begin
      mem[wbin[ADDR_W-1:0]] <= wdata;
    end
  end

  // Read side next-state: accept, advance the pointer and measure occupancy.
  always_comb begin
    ren         = rinc & ~rempty;
    rbin_next   = rbin + PW'(ren);
    rgray_next  = PW'(bin2gray(PTR_MAX_W'(rbin_next)));
    rq_wbin     = PW'(gray2bin(PTR_MAX_W'(rq_wptr)));
    rlevel_next = rq_wbin - rbin_next;
  end

  // Read pointers, read data register and read-side flags.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      rvalid        <= 1'b0;
      rdata         <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq_wptr);
      ralmost_empty <= (rlevel_next <= AEMPTY_LV);
      rlevel        <= rlevel_next;
      rvalid        <= ren;
      if (ren) begin
        rdata <= mem[rbin[ADDR_W-1:0]];
      end
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  // Sticky flag for a write attempted while full.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      woverflow <= 1'b0;
    end else if (winc & wfull) begin
      woverflow <= 1'b1;
    end
  end

  // Sticky flag for a read attempted while empty.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      runderflow <= 1'b0;
    end else if (rinc & rempty) begin
      runderflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: a queue holds every accepted write,
// and a read-clock monitor pops and compares whenever rvalid is presented.
`timescale 1ns/1ps
module tb_async_fifo_param;

  localparam int WIDTH     = 8;
  localparam int ADDR_W    = 6;
  localparam int DEPTH     = 64;
  localparam int AFULL_TH  = 60;
  localparam int AEMPTY_TH = 4;

  logic              wclk  = 1'b0;
  logic              rclk  = 1'b0;
  logic              rst_n = 1'b1;
  logic              winc  = 1'b0;
  logic              rinc  = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic [WIDTH-1:0]  rdata;
  logic              wfull, walmost_full, rvalid, rempty, ralmost_empty;
  logic [ADDR_W:0]   wlevel, rlevel;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic              woverflow, runderflow;
`endif

  realtime whalf = 5.0;
  realtime rhalf = 11.5;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] sb [$];
  logic             pend = 1'b0;
  logic [WIDTH-1:0] last_rd = '0;

  async_fifo_param #(
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2),
    .AFULL_TH    (AFULL_TH),
    .AEMPTY_TH   (AEMPTY_TH)
  ) dut (
    .wclk          (wclk),
    .rclk          (rclk),
    .rst_n         (rst_n),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .woverflow     (woverflow),
    .runderflow    (runderflow)
`endif
  );

  always #(whalf) wclk = ~wclk;
  always #(rhalf) rclk = ~rclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted at one rclk edge must show rvalid with the oldest queued word.
  always @(negedge rclk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (rvalid || pend) begin
        checkOutput("rvalid", 32'(rvalid), 32'(pend));
        if (rvalid && pend) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_underrun: got word 0x%0h, expected none queued at %0t", rdata, $time);
          end else begin
            checkOutput("rdata", 32'(rdata), 32'(sb.pop_front()));
          end
          last_rd = rdata;
        end
      end
      pend = rinc && !rempty;
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_wfull"}, 32'(wfull), 32'(0));
    checkOutput({tag, "_walmost_full"}, 32'(walmost_full), 32'(0));
    checkOutput({tag, "_wlevel"}, 32'(wlevel), 32'(0));
    checkOutput({tag, "_rempty"}, 32'(rempty), 32'(1));
    checkOutput({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'(1));
    checkOutput({tag, "_rlevel"}, 32'(rlevel), 32'(0));
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'(0));
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'(0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    checkOutput({tag, "_woverflow"}, 32'(woverflow), 32'(0));
    checkOutput({tag, "_runderflow"}, 32'(runderflow), 32'(0));
`endif
  endtask

  task automatic write_burst(input int n, input int base);
    @(posedge wclk); #1;
    for (int k = 0; k < n; k++) begin
      winc  = 1'b1;
      wdata = WIDTH'(base + k);
      sb.push_back(WIDTH'(base + k));
      @(posedge wclk); #1;
    end
    winc = 1'b0;
  endtask

  task automatic drain_fifo(input string tag);
    int g;
    g = 0;
    @(posedge rclk); #1;
    rinc = 1'b1;
    do begin
      @(posedge rclk); #1;
      g++;
    end while (!rempty && g < 500);
    rinc = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  // Random concurrent traffic; only requests the DUT can accept enter the scoreboard.
  task automatic applyStimulus(input int n, input int wprob, input int rprob, input string tag);
    int wr_cnt;
    int rd_cnt;
    wr_cnt = 0;
    rd_cnt = 0;
    fork
      begin
        int g;
        g = 0;
        while (wr_cnt < n && g < n * 6) begin
          @(posedge wclk); #1;
          g++;
          winc  = ($urandom_range(0, 99) < wprob);
          wdata = WIDTH'($urandom);
          if (winc && !wfull) begin
            sb.push_back(wdata);
            wr_cnt++;
          end
        end
        @(posedge wclk); #1;
        winc = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (rd_cnt < n && g < n * 6) begin
          @(posedge rclk); #1;
          g++;
          rinc = ($urandom_range(0, 99) < rprob);
          if (rinc && !rempty) rd_cnt++;
        end
        @(posedge rclk); #1;
        rinc = 1'b0;
      end
    join
    repeat (4) @(posedge rclk);
    #1;
    checkOutput({tag, "_writes"}, 32'(wr_cnt), 32'(n));
    checkOutput({tag, "_reads"}, 32'(rd_cnt), 32'(n));
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #20ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    realtime t_w;
    int      n_edges;
    bit      seen;

    // Reset and idle
    #2 rst_n = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check_reset_values("reset");
    @(negedge wclk);
    rst_n = 1'b1;
    repeat (5) @(posedge rclk);
    #1;
    check_reset_values("idle");

    // Fill to full with no reads
    @(posedge wclk); #1;
    for (int k = 0; k < DEPTH; k++) begin
      winc  = 1'b1;
      wdata = WIDTH'(k);
      sb.push_back(WIDTH'(k));
      @(posedge wclk); #1;
      checkOutput("fill_wlevel", 32'(wlevel), 32'(k + 1));
      checkOutput("fill_walmost_full", 32'(walmost_full), 32'((k + 1) >= AFULL_TH));
      checkOutput("fill_wfull", 32'(wfull), 32'((k + 1) == DEPTH));
    end
    wdata = 8'hFF;
    @(posedge wclk); #1;
    winc = 1'b0;
    checkOutput("overfill_wlevel", 32'(wlevel), 32'(DEPTH));
    checkOutput("overfill_wfull", 32'(wfull), 32'(1));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    checkOutput("overfill_woverflow", 32'(woverflow), 32'(1));
`endif

    // Drain with continuous rinc
    repeat (5) @(posedge rclk);
    #1;
    checkOutput("full_rlevel", 32'(rlevel), 32'(DEPTH));
    begin
      int rd_cnt;
      int g;
      rd_cnt = 0;
      g = 0;
      @(posedge rclk); #1;
      rinc = 1'b1;
      while (rd_cnt < DEPTH && g < 1000) begin
        if (!rempty) rd_cnt++;
        @(posedge rclk); #1;
        g++;
      end
      checkOutput("drain_count", 32'(rd_cnt), 32'(DEPTH));
      checkOutput("drain_rempty", 32'(rempty), 32'(1));
      checkOutput("drain_rlevel", 32'(rlevel), 32'(0));
      checkOutput("drain_ralmost_empty", 32'(ralmost_empty), 32'(1));
      @(posedge rclk); #1;
      rinc = 1'b0;
      checkOutput("extra_rinc_rvalid", 32'(rvalid), 32'(0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
      checkOutput("extra_rinc_runderflow", 32'(runderflow), 32'(1));
`endif
    end
    repeat (3) @(posedge rclk);
    #1;
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'(0));
    repeat (5) @(posedge wclk);
    #1;
    checkOutput("freed_wlevel", 32'(wlevel), 32'(0));
    checkOutput("freed_wfull", 32'(wfull), 32'(0));

    // Random traffic at 3:7 and 7:3 clock ratios
    whalf = 15.0;
    rhalf = 35.0;
    applyStimulus(5000, 50, 90, "ratio_3_7");
    whalf = 35.0;
    rhalf = 15.0;
    applyStimulus(5000, 90, 50, "ratio_7_3");
    whalf = 5.0;
    rhalf = 11.5;
    repeat (10) @(posedge rclk);

    // Single-word latency to rempty falling
    @(posedge wclk); #1;
    winc  = 1'b1;
    wdata = 8'h5A;
    sb.push_back(8'h5A);
    @(posedge wclk);
    t_w = $realtime;
    fork
      begin
        #1 winc = 1'b0;
      end
    join_none
    n_edges = 0;
    seen    = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(posedge rclk);
      if ($realtime > t_w) begin
        n_edges++;
        #1;
        if (!rempty) seen = 1'b1;
      end
    end
    checkOutput("latency_rclk_edges", 32'(n_edges), 32'(3));

    // Almost-empty threshold as the read-side level climbs
    repeat (6) @(posedge rclk);
    #1;
    checkOutput("aempty_rlevel", 32'(rlevel), 32'(1));
    checkOutput("aempty_flag", 32'(ralmost_empty), 32'(1));
    for (int k = 2; k <= 6; k++) begin
      write_burst(1, k);
      repeat (6) @(posedge rclk);
      #1;
      checkOutput("aempty_rlevel", 32'(rlevel), 32'(k));
      checkOutput("aempty_flag", 32'(ralmost_empty), 32'(k <= AEMPTY_TH));
    end
    drain_fifo("aempty");

    // Reset in the middle of a stream at level 20
    write_burst(20, 8'h30);
    repeat (6) @(posedge rclk);
    #1;
    checkOutput("pre_reset_wlevel", 32'(wlevel), 32'(20));
    checkOutput("pre_reset_rlevel", 32'(rlevel), 32'(20));
    @(negedge wclk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(posedge rclk);
    @(negedge wclk);
    rst_n = 1'b1;
    repeat (5) @(posedge rclk);
    write_burst(1, 8'hA5);
    repeat (6) @(posedge rclk);
    drain_fifo("post_reset");
    checkOutput("post_reset_readback", 32'(last_rd), 32'(8'hA5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
